// File: rtl/knn_result_drain.sv
// knn_result_drain: reads the k nearest results out of the sorter and streams them nearest-first.
// Optional build macro RANK_TAG_EN adds m_rank per beat and the dbg_beats accepted-beat counter.
module knn_result_drain #(
   parameter int DATA_WIDTH = 32,
   parameter int MAX_K      = 16,
   parameter int FIFO_DEPTH = 4,
   localparam int IW        = (MAX_K > 1) ? $clog2(MAX_K) : 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [31:0]           k,
   output logic                  rd_en,
   output logic [IW-1:0]         rd_idx,
   input  logic [31:0]           rd_name,
   input  logic [DATA_WIDTH-1:0] rd_value,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [31:0]           m_name,
   output logic [DATA_WIDTH-1:0] m_value,
   output logic                  m_last,
`ifdef RANK_TAG_EN
   output logic [IW-1:0]         m_rank,
   output logic [31:0]           dbg_beats,
`endif
   output logic                  busy,
   output logic                  done,
   output logic                  k_err
);

   localparam int CW = $clog2(MAX_K + 1);
   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
`ifdef RANK_TAG_EN
   localparam int EW = IW + 32 + DATA_WIDTH + 1;
`else
   localparam int EW = 32 + DATA_WIDTH + 1;
`endif
   localparam logic [CW-1:0] KMAX = CW'(MAX_K);

   typedef enum logic [1:0] {
      S_IDLE,
      S_FETCH,
      S_FLUSH,
      S_FIN
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] keff_q, keff_d;
   logic [CW-1:0] issue_q, issue_d;
   logic          kerr_q, kerr_d;

   logic          infl_q;
   logic          infl_last_q;
`ifdef RANK_TAG_EN
   logic [IW-1:0] infl_rank_q;
   logic [31:0]   beats_q;
`endif

   logic [EW-1:0] mem_q [FIFO_DEPTH];
   logic [AW-1:0] wptr_q, rptr_q;
   logic [AW:0]   cnt_q, cnt_d;
   logic [EW-1:0] head;
   logic [EW-1:0] wr_ent;

   logic          push;
   logic          pop;
   logic          room;
   logic          is_last_rank;
   logic          k_over;
   logic [CW-1:0] k_clip;

   assign k_over       = (k > 32'(MAX_K));
   assign k_clip       = k_over ? KMAX : k[CW-1:0];
   assign is_last_rank = (issue_q == (keff_q - CW'(1)));

   // A read is only issued when the slot it will land in is guaranteed free.
   assign room = ((int'(cnt_q) + int'(infl_q)) < FIFO_DEPTH);

   assign head    = mem_q[rptr_q];
   assign push    = infl_q;
   assign m_valid = (cnt_q != '0);
   assign pop     = m_valid & m_ready;

   assign m_last  = m_valid & head[0];
   assign m_value = m_valid ? head[DATA_WIDTH:1] : '0;
   assign m_name  = m_valid ? head[DATA_WIDTH+32:DATA_WIDTH+1] : '0;

`ifdef RANK_TAG_EN
   assign wr_ent    = {infl_rank_q, rd_name, rd_value, infl_last_q};
   assign m_rank    = m_valid ? head[EW-1 -: IW] : '0;
   assign dbg_beats = beats_q;
`else
   assign wr_ent = {rd_name, rd_value, infl_last_q};
`endif

   assign rd_idx = rd_en ? issue_q[IW-1:0] : '0;
   assign busy   = (state_q != S_IDLE);
   assign done   = (state_q == S_FIN);
   assign k_err  = kerr_q;

   // Next-state, read issue and query-parameter capture.
   always_comb begin
      state_d = state_q;
      keff_d  = keff_q;
      kerr_d  = kerr_q;
      issue_d = issue_q;
      rd_en   = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               keff_d  = k_clip;
               kerr_d  = k_over;
               issue_d = '0;
               state_d = (k_clip == '0) ? S_FIN : S_FETCH;
            end
         end
         S_FETCH: begin
            if (room) begin
               rd_en   = 1'b1;
               issue_d = issue_q + CW'(1);
               if (is_last_rank) begin
                  state_d = S_FLUSH;
               end
            end
         end
         S_FLUSH: begin
            if (pop && head[0]) begin
               state_d = S_FIN;
            end
         end
         S_FIN: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Control state and per-query registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         keff_q  <= '0;
         kerr_q  <= 1'b0;
         issue_q <= '0;
      end else begin
         state_q <= state_d;
         keff_q  <= keff_d;
         kerr_q  <= kerr_d;
         issue_q <= issue_d;
      end
   end

   // Track the single outstanding sorter read and its tag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         infl_q      <= 1'b0;
         infl_last_q <= 1'b0;
`ifdef RANK_TAG_EN
         infl_rank_q <= '0;
`endif
      end else begin
         infl_q      <= rd_en;
         infl_last_q <= rd_en & is_last_rank;
`ifdef RANK_TAG_EN
         infl_rank_q <= issue_q[IW-1:0];
`endif
      end
   end

   // FIFO occupancy after this cycle's push and pop.
   always_comb begin
      cnt_d = cnt_q;
      if (push && !pop) begin
         cnt_d = cnt_q + (AW+1)'(1);
      end else if (pop && !push) begin
         cnt_d = cnt_q - (AW+1)'(1);
      end
   end

   // FIFO pointers and count.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         if (push) begin
            wptr_q <= wptr_q + AW'(1);
         end
         if (pop) begin
            rptr_q <= rptr_q + AW'(1);
         end
         cnt_q <= cnt_d;
      end
   end

   // FIFO storage; contents are masked at the outputs while empty.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wptr_q] <= wr_ent;
      end
   end

`ifdef RANK_TAG_EN
   // Count every beat the host accepts since reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         beats_q <= '0;
      end else if (pop) begin
         beats_q <= beats_q + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_knn_result_drain.sv
// tb_knn_result_drain: directed queries against a queue-based model of the drained stream.
// Build with RANK_TAG_EN defined to also cover m_rank and dbg_beats.
module tb_knn_result_drain;

   localparam int DW = 32;
   localparam int MK = 16;
   localparam int FD = 4;
   localparam int IW = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic [31:0]   k = '0;
   logic          m_ready = 1'b0;
   logic          rd_en;
   logic [IW-1:0] rd_idx;
   logic [31:0]   rd_name = '0;
   logic [DW-1:0] rd_value = '0;
   logic          m_valid;
   logic [31:0]   m_name;
   logic [DW-1:0] m_value;
   logic          m_last;
   logic          busy;
   logic          done;
   logic          k_err;
`ifdef RANK_TAG_EN
   logic [IW-1:0] m_rank;
   logic [31:0]   dbg_beats;
`endif

   knn_result_drain #(
      .DATA_WIDTH(DW),
      .MAX_K(MK),
      .FIFO_DEPTH(FD)
   ) dut (
      .clk(clk),
      .reset(reset),
      .start(start),
      .k(k),
      .rd_en(rd_en),
      .rd_idx(rd_idx),
      .rd_name(rd_name),
      .rd_value(rd_value),
      .m_valid(m_valid),
      .m_ready(m_ready),
      .m_name(m_name),
      .m_value(m_value),
      .m_last(m_last),
`ifdef RANK_TAG_EN
      .m_rank(m_rank),
      .dbg_beats(dbg_beats),
`endif
      .busy(busy),
      .done(done),
      .k_err(k_err)
   );

   always #5 clk = ~clk;

   logic [31:0]   names [MK];
   logic [DW-1:0] vals [MK];

   // Sorter result buffer: one-cycle registered read.
   always @(posedge clk) begin
      if (rd_en) begin
         rd_name  <= names[rd_idx];
         rd_value <= vals[rd_idx];
      end
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Model state: expected beats of the current query and protocol bookkeeping.
   int          cyc = 0;
   bit          busy_x, done_x, kerr_x;
   int          keff_x, issue_x, outst;
   logic [31:0] q_name [$];
   logic [DW-1:0] q_val [$];
   bit          q_last [$];
   int          q_rank [$];

   logic [31:0] log_name [$];
   logic [DW-1:0] log_val [$];
   bit          log_last [$];
   int          log_rank [$];

   bit          stall_p;
   logic [31:0] pn;
   logic [DW-1:0] pv;
   logic        pl;

   int start_neg, first_v_neg, first_a_neg, last_a_neg, done_neg;
   int busy_cycles, rd_cnt;
   bit got_done;

   // Compare DUT against the model once per cycle, then advance the model.
   always @(negedge clk) begin
      bit acc;
      bit dn;
      bit lastpop;
      cyc++;
      if (reset) begin
         chk("rst_m_valid", m_valid, 0);
         chk("rst_busy", busy, 0);
         chk("rst_done", done, 0);
         chk("rst_rd_en", rd_en, 0);
         chk("rst_k_err", k_err, 0);
         busy_x = 0; done_x = 0; kerr_x = 0;
         keff_x = 0; issue_x = 0; outst = 0;
         stall_p = 0;
         q_name.delete(); q_val.delete(); q_last.delete(); q_rank.delete();
      end else begin
         chk("done", done, done_x);
         chk("busy", busy, busy_x);
         chk("k_err", k_err, kerr_x);
         if (busy) busy_cycles++;
         if (done) begin
            got_done = 1;
            done_neg = cyc;
         end
         if (stall_p) begin
            chk("hold_valid", m_valid, 1);
            chk("hold_name", m_name, pn);
            chk("hold_value", m_value, pv);
            chk("hold_last", m_last, pl);
         end
         if (m_valid && first_v_neg < 0) first_v_neg = cyc;
         if (m_valid) chk("beat_expected", q_name.size() != 0, 1);
         if (rd_en) begin
            rd_cnt++;
            chk("rd_idx", rd_idx, issue_x);
            chk("rd_in_range", issue_x < keff_x, 1);
            chk("rd_room", outst < FD, 1);
            issue_x++;
         end
         acc = m_valid && m_ready && q_name.size() != 0;
         lastpop = 0;
         if (acc) begin
            chk("m_name", m_name, q_name[0]);
            chk("m_value", m_value, q_val[0]);
            chk("m_last", m_last, q_last[0]);
`ifdef RANK_TAG_EN
            chk("m_rank", m_rank, q_rank[0]);
            log_rank.push_back(int'(m_rank));
`endif
            log_name.push_back(m_name);
            log_val.push_back(m_value);
            log_last.push_back(m_last);
            lastpop = q_last[0];
            void'(q_name.pop_front());
            void'(q_val.pop_front());
            void'(q_last.pop_front());
            void'(q_rank.pop_front());
            if (first_a_neg < 0) first_a_neg = cyc;
            last_a_neg = cyc;
         end
         outst = outst + (rd_en ? 1 : 0) - (acc ? 1 : 0);
         stall_p = m_valid && !m_ready;
         pn = m_name; pv = m_value; pl = m_last;
         dn = acc && lastpop;
         if (!busy_x && start) begin
            keff_x = (k > MK) ? MK : int'(k);
            kerr_x = (k > MK);
            busy_x = 1;
            issue_x = 0;
            start_neg = cyc;
            for (int r = 0; r < keff_x; r++) begin
               q_name.push_back(names[r]);
               q_val.push_back(vals[r]);
               q_last.push_back(r == keff_x - 1);
               q_rank.push_back(r);
            end
            if (keff_x == 0) dn = 1;
         end else if (done_x) begin
            busy_x = 0;
         end
         done_x = dn;
      end
   end

   task automatic clear_logs();
      log_name.delete(); log_val.delete(); log_last.delete(); log_rank.delete();
      got_done = 0; busy_cycles = 0; rd_cnt = 0;
      first_v_neg = -1; first_a_neg = -1; last_a_neg = -1; done_neg = -1;
   endtask

   task automatic do_start(input logic [31:0] kv);
      @(posedge clk); #2;
      start = 1'b1;
      k = kv;
      @(posedge clk); #2;
      start = 1'b0;
      k = '0;
   endtask

   // mode 0: m_ready held high; mode 1: m_ready pattern 1,0,0,1.
   task automatic run_q(input logic [31:0] kv, input int mode);
      int ph;
      ph = 0;
      clear_logs();
      m_ready = 1'b1;
      do_start(kv);
      for (int c = 0; c < 400 && !got_done; c++) begin
         @(posedge clk); #2;
         if (mode == 1) begin
            m_ready = (ph == 0 || ph == 3);
            ph = (ph + 1) % 4;
         end
      end
      chk("done_timeout", got_done, 1);
      m_ready = 1'b1;
      @(posedge clk); #2;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int nlast;
      for (int i = 0; i < MK; i++) begin
         names[i] = 32'(10 + i);
         vals[i]  = DW'(40 + 7 * (i - 3));
      end
      vals[0] = 5; vals[1] = 9; vals[2] = 20; vals[3] = 40;

      repeat (3) @(posedge clk);
      #2;
      chk("reset_m_valid", m_valid, 0);
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_k_err", k_err, 0);
      chk("reset_rd_en", rd_en, 0);
      reset = 1'b0;
      @(posedge clk); #2;

      // Basic drain, k=4.
      run_q(4, 0);
      chk("basic_count", log_name.size(), 4);
      if (log_name.size() == 4) begin
         chk("basic_n0", log_name[0], 10);
         chk("basic_n3", log_name[3], 13);
         chk("basic_v1", log_val[1], 9);
         chk("basic_v2", log_val[2], 20);
         chk("basic_v3", log_val[3], 40);
         chk("basic_last2", log_last[2], 0);
         chk("basic_last3", log_last[3], 1);
      end
      // Start seen at negedge N, sampled by the next edge, first beat visible two edges later.
      chk("first_valid_lat", first_v_neg - start_neg, 3);
      chk("back_to_back", last_a_neg - first_a_neg, 3);
      chk("done_after_last", done_neg - last_a_neg, 1);
      chk("basic_k_err", k_err, 0);

      // Backpressure, k=8.
      run_q(8, 1);
      chk("bp_count", log_name.size(), 8);
      chk("bp_reads", rd_cnt, 8);
      if (log_name.size() == 8) begin
         for (int i = 0; i < 8; i++) chk("bp_order", log_name[i], 10 + i);
         chk("bp_last", log_last[7], 1);
      end

      // k=0: no beats, one busy cycle, done right after start.
      run_q(0, 0);
      chk("k0_beats", log_name.size(), 0);
      chk("k0_reads", rd_cnt, 0);
      chk("k0_busy_cycles", busy_cycles, 1);
      chk("k0_done_lat", done_neg - start_neg, 1);

      // Overflow k clipped to MAX_K.
      run_q(40, 0);
      chk("ovf_count", log_name.size(), 16);
      nlast = 0;
      foreach (log_last[i]) nlast += log_last[i];
      chk("ovf_nlast", nlast, 1);
      if (log_name.size() == 16) begin
         chk("ovf_name15", log_name[15], 25);
         chk("ovf_last15", log_last[15], 1);
      end
      chk("ovf_k_err", k_err, 1);
      run_q(2, 0);
      chk("kerr_cleared", k_err, 0);
      chk("k2_count", log_name.size(), 2);

      // Ignored second start, then async reset after 3 of 8 beats.
      clear_logs();
      m_ready = 1'b1;
      do_start(8);
      do_start(2);
      for (int c = 0; c < 100 && log_name.size() < 3; c++) begin
         @(posedge clk); #2;
      end
      chk("pre_reset_beats", log_name.size(), 3);
      reset = 1'b1;
      #1;
      chk("rst_mid_valid", m_valid, 0);
      chk("rst_mid_busy", busy, 0);
      repeat (2) @(posedge clk);
      #2;
      reset = 1'b0;
      chk("rst_mid_no_done", got_done, 0);
      if (log_name.size() == 3) chk("pre_reset_n2", log_name[2], 12);
      run_q(8, 0);
      chk("post_rst_count", log_name.size(), 8);
      if (log_name.size() == 8) begin
         chk("post_rst_n0", log_name[0], 10);
         chk("post_rst_n7", log_name[7], 17);
      end

`ifdef RANK_TAG_EN
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #2;
      reset = 1'b0;
      run_q(3, 0);
      chk("rank_count", log_rank.size(), 3);
      if (log_rank.size() == 3) begin
         chk("rank0", log_rank[0], 0);
         chk("rank1", log_rank[1], 1);
         chk("rank2", log_rank[2], 2);
      end
      chk("dbg_beats_3", dbg_beats, 3);
      run_q(3, 0);
      chk("dbg_beats_6", dbg_beats, 6);
`endif

      repeat (2) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
